// File: rtl/add_seq_pkg.sv
// Shared types and constants for the multi-slice add sequencer.
// Slice width, FSM state encoding and the slice-index width helper.
package add_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // clog2(nwords), kept at least 1 bit so NWORDS=1 still has a legal index
    function automatic int idx_w(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/add_seq_slice_mux.sv
// Selects one 16-bit slice, by index, out of a packed multi-slice vector.
module add_seq_slice_mux
    import add_seq_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int IW     = 2
) (
    input  logic [SLICE_W*NWORDS-1:0] vec,
    input  logic [IW-1:0]             idx,
    output logic [SLICE_W-1:0]        slice
);

    always_comb begin
        // NOTE: default assignment first so no path leaves slice unassigned (no latch).
        slice = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx == IW'(i)) slice = vec[i*SLICE_W +: SLICE_W];
        end
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide-add sequencer: streams NWORDS 16-bit slices LSB-first through one shared adder.
// Optional macro ADD_SEQ_SUB_EN adds the op_sub input for subtraction (A + ~B + 1).
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*NWORDS-1:0] op_a,
    input  logic [SLICE_W*NWORDS-1:0] op_b,
    input  logic                      cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                      op_sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*NWORDS-1:0] result,
    output logic                      carry_out,
    output logic                      overflow,
    output logic                      busy,
    output logic [SLICE_W-1:0]        adder_a,
    output logic [SLICE_W-1:0]        adder_b,
    output logic                      adder_cin,
    input  logic [SLICE_W-1:0]        adder_sum,
    input  logic                      adder_cout
);

    localparam int W  = SLICE_W * NWORDS;
    localparam int IW = idx_w(NWORDS);

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;     // holds B' (already inverted when subtracting)
    logic [IW-1:0]   idx;
    logic            carry_reg;
    logic [W-1:0]    b_eff;
    logic            cin_eff;
    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;

`ifdef ADD_SEQ_SUB_EN
    assign b_eff   = op_sub ? ~op_b : op_b;
    assign cin_eff = op_sub | cin;
`else
    assign b_eff   = op_b;
    assign cin_eff = cin;
`endif

    add_seq_slice_mux #(.NWORDS(NWORDS), .IW(IW)) u_mux_a (
        .vec   (a_reg),
        .idx   (idx),
        .slice (a_slice)
    );

    add_seq_slice_mux #(.NWORDS(NWORDS), .IW(IW)) u_mux_b (
        .vec   (b_reg),
        .idx   (idx),
        .slice (b_slice)
    );

    // Adder inputs are decoded from registered state and forced to zero outside RUN
    assign adder_a   = (state == RUN) ? a_slice   : '0;
    assign adder_b   = (state == RUN) ? b_slice   : '0;
    assign adder_cin = (state == RUN) ? carry_reg : 1'b0;

    // NOTE: operand storage has no reset; it is only read in RUN, which always follows a load.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && in_ready) begin
            a_reg <= op_a;
            b_reg <= b_eff;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            idx       <= '0;
            carry_reg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        carry_reg <= cin_eff;
                        idx       <= '0;
                        result    <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NWORDS; i++) begin
                        if (idx == IW'(i)) result[i*SLICE_W +: SLICE_W] <= adder_sum;
                    end
                    carry_reg <= adder_cout;
                    idx       <= idx + IW'(1);
                    if (idx == IW'(NWORDS - 1)) begin
                        carry_out <= adder_cout;
                        overflow  <= (a_reg[W-1] == b_reg[W-1]) &&
                                     (adder_sum[SLICE_W-1] != a_reg[W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
